// File: rtl/muu_resp_pkg.sv
// rtl/muu_resp_pkg.sv - shared states, wire-format field offsets and error codes for the response parser
package muu_resp_pkg;

  typedef enum logic [1:0] {
    S_HDR   = 2'd0,
    S_INFO  = 2'd1,
    S_VALUE = 2'd2,
    S_DROP  = 2'd3
  } state_t;

  localparam logic [15:0] MAGIC = 16'hFFFF;

  localparam int NWORDS_W = 10;

  localparam int W0_MAGIC_LSB  = 0;
  localparam int W0_CODE_B_LSB = 16;
  localparam int W0_CODE_A_LSB = 24;
  localparam int W0_NWORDS_LSB = 32;

  localparam int W1_PTR_LSB = 0;
  localparam int W1_LEN_LSB = 32;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_MAGIC = 2'd1;
  localparam logic [1:0] ERR_SHORT = 2'd2;
  localparam logic [1:0] ERR_LONG  = 2'd3;

  localparam int HDR_FIXED_W = 8 + 8 + 8 + NWORDS_W + 32 + 16;

endpackage

// File: rtl/muu_out_reg512.sv
// rtl/muu_out_reg512.sv - single-entry valid/ready output register; data held stable while stalled
module muu_out_reg512 #(
  parameter int WIDTH = 512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  assign in_ready  = !r_valid || out_ready;
  assign out_valid = r_valid;
  assign out_data  = r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (in_valid && in_ready) begin
      r_valid <= 1'b1;
      r_data  <= in_data;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/muu_resp_parse512.sv
// rtl/muu_resp_parse512.sv - splits a response stream into header and value streams with error pulses
// Optional counters stat_pkts/stat_errs when MUU_RESP_PARSE_STATS_EN is defined.
module muu_resp_parse512
  import muu_resp_pkg::*;
#(
  parameter int MEMORY_WIDTH    = 512,
  parameter int META_WIDTH      = 96,
  parameter int MAX_VALUE_WORDS = 1023
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [META_WIDTH+MEMORY_WIDTH-1:0] in_data,
  input  logic [7:0]                         in_user,
  input  logic                               in_valid,
  input  logic                               in_last,
  output logic                               in_ready,
  output logic [HDR_FIXED_W+META_WIDTH-1:0]  hdr_data,
  output logic                               hdr_valid,
  input  logic                               hdr_ready,
  output logic [MEMORY_WIDTH-1:0]            val_data,
  output logic                               val_valid,
  output logic                               val_last,
  input  logic                               val_ready,
  output logic                               err_valid,
  output logic [1:0]                         err_code
`ifdef MUU_RESP_PARSE_STATS_EN
  ,
  output logic [31:0]                        stat_pkts,
  output logic [31:0]                        stat_errs
`endif
);

  localparam int HDR_W  = HDR_FIXED_W + META_WIDTH;
  localparam int LP_MAX = MAX_VALUE_WORDS;

  state_t r_state;
  state_t w_state_nxt;

  logic [7:0]            r_user;
  logic [7:0]            r_code_a;
  logic [7:0]            r_code_b;
  logic [NWORDS_W-1:0]   r_nwords;
  logic [META_WIDTH-1:0] r_meta;
  logic [NWORDS_W-1:0]   r_remaining;
  logic                  r_err_valid;
  logic [1:0]            r_err_code;

  logic [MEMORY_WIDTH-1:0] w_word;
  logic [META_WIDTH-1:0]   w_meta;
  logic [15:0]             w_magic;
  logic [7:0]              w_code_a;
  logic [7:0]              w_code_b;
  logic [NWORDS_W-1:0]     w_nwords;
  logic [31:0]             w_ptr;
  logic [15:0]             w_len;
  logic                    w_nwords_bad;
  logic                    w_hdr_ok;
  logic                    w_accept;
  logic                    w_hdr_rdy;
  logic                    w_val_rdy;

  logic             w_hdr_load;
  logic [HDR_W-1:0] w_hdr_din;
  logic             w_val_load;
  logic             w_val_last;
  logic             w_err_fire;
  logic [1:0]       w_err_code;

  assign w_word   = in_data[MEMORY_WIDTH-1:0];
  assign w_meta   = in_data[MEMORY_WIDTH +: META_WIDTH];
  assign w_magic  = w_word[W0_MAGIC_LSB +: 16];
  assign w_code_b = w_word[W0_CODE_B_LSB +: 8];
  assign w_code_a = w_word[W0_CODE_A_LSB +: 8];
  assign w_nwords = w_word[W0_NWORDS_LSB +: NWORDS_W];
  assign w_ptr    = w_word[W1_PTR_LSB +: 32];
  assign w_len    = w_word[W1_LEN_LSB +: 16];

  // An oversized count is indistinguishable from a corrupt header, so it shares the magic error.
  assign w_nwords_bad = (32'(w_nwords) > LP_MAX);
  assign w_hdr_ok     = (w_magic == MAGIC) && !w_nwords_bad;
  assign w_accept     = in_valid && in_ready;

  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      case (r_state)
        S_HDR, S_INFO: in_ready = w_hdr_rdy;
        S_VALUE:       in_ready = w_val_rdy;
        default:       in_ready = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_HDR;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      case (r_state)
        S_HDR: begin
          if (!w_hdr_ok)     w_state_nxt = in_last ? S_HDR : S_DROP;
          else if (!in_last) w_state_nxt = S_INFO;
        end
        S_INFO: begin
          if (in_last)              w_state_nxt = S_HDR;
          else if (r_nwords == '0)  w_state_nxt = S_DROP;
          else                      w_state_nxt = S_VALUE;
        end
        S_VALUE: begin
          if (in_last)                       w_state_nxt = S_HDR;
          else if (r_remaining == 10'd1)     w_state_nxt = S_DROP;
        end
        default: begin
          if (in_last) w_state_nxt = S_HDR;
        end
      endcase
    end
  end

  always_comb begin
    w_hdr_load = 1'b0;
    w_hdr_din  = {r_user, r_code_a, r_code_b, r_nwords, w_ptr, w_len, r_meta};
    w_val_load = 1'b0;
    w_val_last = 1'b0;
    w_err_fire = 1'b0;
    w_err_code = ERR_NONE;
    if (w_accept) begin
      case (r_state)
        S_HDR: begin
          if (!w_hdr_ok) begin
            w_err_fire = 1'b1;
            w_err_code = ERR_MAGIC;
          end else if (in_last) begin
            w_hdr_load = 1'b1;
            w_hdr_din  = {in_user, w_code_a, w_code_b, {NWORDS_W{1'b0}}, 32'd0, 16'd0, w_meta};
          end
        end
        S_INFO: begin
          w_hdr_load = 1'b1;
          if (in_last && r_nwords != '0) begin
            w_err_fire = 1'b1;
            w_err_code = ERR_SHORT;
          end else if (!in_last && r_nwords == '0) begin
            w_err_fire = 1'b1;
            w_err_code = ERR_LONG;
          end
        end
        S_VALUE: begin
          w_val_load = 1'b1;
          w_val_last = in_last || (r_remaining == 10'd1);
          if (in_last && r_remaining != 10'd1) begin
            w_err_fire = 1'b1;
            w_err_code = ERR_SHORT;
          end else if (!in_last && r_remaining == 10'd1) begin
            w_err_fire = 1'b1;
            w_err_code = ERR_LONG;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_user      <= '0;
      r_code_a    <= '0;
      r_code_b    <= '0;
      r_nwords    <= '0;
      r_meta      <= '0;
      r_remaining <= '0;
      r_err_valid <= 1'b0;
      r_err_code  <= ERR_NONE;
    end else begin
      r_err_valid <= w_err_fire;
      if (w_err_fire) r_err_code <= w_err_code;
      if (r_state == S_HDR && w_accept && w_hdr_ok) begin
        r_user   <= in_user;
        r_code_a <= w_code_a;
        r_code_b <= w_code_b;
        r_nwords <= w_nwords;
        r_meta   <= w_meta;
      end
      if (r_state == S_INFO && w_accept) r_remaining <= r_nwords;
      else if (w_val_load)               r_remaining <= r_remaining - 10'd1;
    end
  end

  assign err_valid = r_err_valid;
  assign err_code  = r_err_code;

  muu_out_reg512 #(.WIDTH(HDR_W)) u_hdr_reg (
    .clk       (clk),
    .rst       (rst),
    .in_data   (w_hdr_din),
    .in_valid  (w_hdr_load),
    .in_ready  (w_hdr_rdy),
    .out_data  (hdr_data),
    .out_valid (hdr_valid),
    .out_ready (hdr_ready)
  );

  muu_out_reg512 #(.WIDTH(MEMORY_WIDTH + 1)) u_val_reg (
    .clk       (clk),
    .rst       (rst),
    .in_data   ({w_val_last, w_word}),
    .in_valid  (w_val_load),
    .in_ready  (w_val_rdy),
    .out_data  ({val_last, val_data}),
    .out_valid (val_valid),
    .out_ready (val_ready)
  );

`ifdef MUU_RESP_PARSE_STATS_EN
  logic [31:0] r_stat_pkts;
  logic [31:0] r_stat_errs;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_pkts <= '0;
      r_stat_errs <= '0;
    end else begin
      if (w_hdr_load) r_stat_pkts <= r_stat_pkts + 32'd1;
      if (w_err_fire) r_stat_errs <= r_stat_errs + 32'd1;
    end
  end

  assign stat_pkts = r_stat_pkts;
  assign stat_errs = r_stat_errs;
`endif

endmodule

// File: tb/tb_muu_resp_parse512.sv
// tb/tb_muu_resp_parse512.sv - scoreboard bench for muu_resp_parse512 (MUU_RESP_PARSE_STATS_EN optional)
module tb_muu_resp_parse512;

  localparam int MW   = 512;
  localparam int META = 96;
  localparam int MAXW = 16;
  localparam int HW   = 82 + META;

  logic             clk = 1'b0;
  logic             rst;
  logic [META+MW-1:0] in_data;
  logic [7:0]       in_user;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [HW-1:0]    hdr_data;
  logic             hdr_valid;
  logic             hdr_ready;
  logic [MW-1:0]    val_data;
  logic             val_valid;
  logic             val_last;
  logic             val_ready;
  logic             err_valid;
  logic [1:0]       err_code;
`ifdef MUU_RESP_PARSE_STATS_EN
  logic [31:0]      stat_pkts;
  logic [31:0]      stat_errs;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int exp_pkts = 0;
  int exp_errs = 0;

  logic [HW-1:0] hq[$];
  logic [MW:0]   vq[$];
  logic [1:0]    eq[$];

  logic            val_toggle = 1'b0;
  logic [META-1:0] meta_cur;
  logic [7:0]      user_cur;

  muu_resp_parse512 #(
    .MEMORY_WIDTH    (MW),
    .META_WIDTH      (META),
    .MAX_VALUE_WORDS (MAXW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_user   (in_user),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .hdr_data  (hdr_data),
    .hdr_valid (hdr_valid),
    .hdr_ready (hdr_ready),
    .val_data  (val_data),
    .val_valid (val_valid),
    .val_last  (val_last),
    .val_ready (val_ready),
    .err_valid (err_valid),
    .err_code  (err_code)
`ifdef MUU_RESP_PARSE_STATS_EN
    ,
    .stat_pkts (stat_pkts),
    .stat_errs (stat_errs)
`endif
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    val_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      val_ready = val_toggle ? ~val_ready : 1'b1;
    end
  end

  function automatic logic [MW-1:0] mk_w0(input logic [15:0] magic, input logic [7:0] ca,
                                          input logic [7:0] cb, input logic [9:0] nw);
    logic [MW-1:0] w;
    w = '0;
    w[MW-1 -: 32] = 32'hDEADBEEF;
    w[15:0]  = magic;
    w[23:16] = cb;
    w[31:24] = ca;
    w[41:32] = nw;
    return w;
  endfunction

  function automatic logic [MW-1:0] mk_w1(input logic [31:0] ptr, input logic [15:0] len);
    logic [MW-1:0] w;
    w = '0;
    w[MW-1 -: 32] = 32'hFEEDF00D;
    w[31:0]  = ptr;
    w[47:32] = len;
    return w;
  endfunction

  function automatic logic [MW-1:0] vw(input int i);
    return {16{32'hC0DE_0000 + 32'(i)}};
  endfunction

  task automatic push_hdr(input logic [7:0] ca, input logic [7:0] cb, input logic [9:0] nw,
                          input logic [31:0] ptr, input logic [15:0] len);
    hq.push_back({user_cur, ca, cb, nw, ptr, len, meta_cur});
    exp_pkts++;
  endtask

  task automatic push_val(input int i, input logic last);
    vq.push_back({last, vw(i)});
  endtask

  task automatic push_err(input logic [1:0] c);
    eq.push_back(c);
    exp_errs++;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic send(input logic [MW-1:0] w, input logic last);
    int  n;
    logic acc;
    n = 0;
    acc = 1'b0;
    in_data  = {meta_cur, w};
    in_user  = user_cur;
    in_last  = last;
    in_valid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout in_ready stuck at 0, required 1");
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((hq.size() != 0 || vq.size() != 0 || eq.size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (hdr_valid && hdr_ready) begin
      n_tests++;
      if (hq.size() == 0) begin
        n_fail++;
        $display("FAIL hdr_unexpected got=%h required none", hdr_data);
      end else if (hdr_data !== hq[0]) begin
        n_fail++;
        $display("FAIL hdr_data got=%h exp=%h", hdr_data, hq[0]);
        void'(hq.pop_front());
      end else begin
        void'(hq.pop_front());
      end
    end
    if (val_valid && val_ready) begin
      n_tests++;
      if (vq.size() == 0) begin
        n_fail++;
        $display("FAIL val_unexpected got=%h last=%b required none", val_data, val_last);
      end else if ({val_last, val_data} !== vq[0]) begin
        n_fail++;
        $display("FAIL val_data got=%h exp=%h", {val_last, val_data}, vq[0]);
        void'(vq.pop_front());
      end else begin
        void'(vq.pop_front());
      end
    end
    if (err_valid) begin
      n_tests++;
      if (eq.size() == 0) begin
        n_fail++;
        $display("FAIL err_unexpected got=%0d required none", err_code);
      end else if (err_code !== eq[0]) begin
        n_fail++;
        $display("FAIL err_code got=%0d exp=%0d", err_code, eq[0]);
        void'(eq.pop_front());
      end else begin
        void'(eq.pop_front());
      end
    end
  end

  initial begin
    int t0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    in_user   = '0;
    hdr_ready = 1'b1;
    user_cur  = 8'h00;
    meta_cur  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_hdr_valid", 32'(hdr_valid), 0);
    chk("rst_val_valid", 32'(val_valid), 0);
    chk("rst_err_valid", 32'(err_valid), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // nominal 3-value packet
    user_cur = 8'h11;
    meta_cur = 96'h0123_4567_89AB_CDEF_0011_2233;
    push_hdr(8'hA5, 8'h5A, 10'd3, 32'h1000, 16'h18);
    send(mk_w0(16'hFFFF, 8'hA5, 8'h5A, 10'd3), 1'b0);
    send(mk_w1(32'h1000, 16'h18), 1'b0);
    push_val(0, 1'b0); send(vw(0), 1'b0);
    push_val(1, 1'b0); send(vw(1), 1'b0);
    push_val(2, 1'b1); send(vw(2), 1'b1);

    // bad magic, then a good packet
    user_cur = 8'h22;
    meta_cur = 96'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF;
    push_err(2'd1);
    send(mk_w0(16'h1234, 8'h01, 8'h02, 10'd3), 1'b0);
    send(vw(9), 1'b0);
    send(vw(9), 1'b0);
    send(vw(9), 1'b1);
    push_hdr(8'h01, 8'h02, 10'd1, 32'h2000, 16'h4);
    send(mk_w0(16'hFFFF, 8'h01, 8'h02, 10'd1), 1'b0);
    send(mk_w1(32'h2000, 16'h4), 1'b0);
    push_val(3, 1'b1); send(vw(3), 1'b1);

    // short value run
    user_cur = 8'h33;
    push_hdr(8'h10, 8'h20, 10'd5, 32'h3000, 16'h28);
    send(mk_w0(16'hFFFF, 8'h10, 8'h20, 10'd5), 1'b0);
    send(mk_w1(32'h3000, 16'h28), 1'b0);
    push_val(4, 1'b0); send(vw(4), 1'b0);
    push_val(5, 1'b1); push_err(2'd2); send(vw(5), 1'b1);

    // long value run, tail dropped
    user_cur = 8'h44;
    push_hdr(8'h30, 8'h40, 10'd2, 32'h4000, 16'h10);
    send(mk_w0(16'hFFFF, 8'h30, 8'h40, 10'd2), 1'b0);
    send(mk_w1(32'h4000, 16'h10), 1'b0);
    push_val(6, 1'b0); send(vw(6), 1'b0);
    push_val(7, 1'b1); push_err(2'd3); send(vw(7), 1'b0);
    send(vw(8), 1'b0);
    send(vw(9), 1'b1);

    // header-only packet: nwords forced to 0
    user_cur = 8'h55;
    push_hdr(8'h77, 8'h88, 10'd0, 32'h0, 16'h0);
    send(mk_w0(16'hFFFF, 8'h77, 8'h88, 10'd7), 1'b1);

    // nwords=0 closed on word1, then nwords=0 with trailing word
    push_hdr(8'h66, 8'h99, 10'd0, 32'h5000, 16'h0);
    send(mk_w0(16'hFFFF, 8'h66, 8'h99, 10'd0), 1'b0);
    send(mk_w1(32'h5000, 16'h0), 1'b1);
    push_hdr(8'h67, 8'h98, 10'd0, 32'h5100, 16'h2);
    push_err(2'd3);
    send(mk_w0(16'hFFFF, 8'h67, 8'h98, 10'd0), 1'b0);
    send(mk_w1(32'h5100, 16'h2), 1'b0);
    send(vw(0), 1'b1);

    // nwords just above and at the maximum
    push_err(2'd1);
    send(mk_w0(16'hFFFF, 8'h01, 8'h01, 10'd17), 1'b1);
    push_hdr(8'h02, 8'h02, 10'd0, 32'h0, 16'h0);
    send(mk_w0(16'hFFFF, 8'h02, 8'h02, 10'd16), 1'b1);
    drain();

    // full throughput with val_ready held high
    user_cur = 8'h66;
    push_hdr(8'hC1, 8'hC2, 10'd4, 32'h6000, 16'h40);
    send(mk_w0(16'hFFFF, 8'hC1, 8'hC2, 10'd4), 1'b0);
    send(mk_w1(32'h6000, 16'h40), 1'b0);
    t0 = cyc;
    for (int i = 0; i < 4; i++) begin
      push_val(20 + i, i == 3);
      send(vw(20 + i), i == 3);
    end
    chk("throughput_cycles", 32'(cyc - t0), 32'd4);

    // val_ready toggling
    val_toggle = 1'b1;
    user_cur = 8'h77;
    push_hdr(8'hD1, 8'hD2, 10'd8, 32'h7000, 16'h80);
    send(mk_w0(16'hFFFF, 8'hD1, 8'hD2, 10'd8), 1'b0);
    send(mk_w1(32'h7000, 16'h80), 1'b0);
    for (int i = 0; i < 8; i++) begin
      push_val(30 + i, i == 7);
      send(vw(30 + i), i == 7);
    end
    drain();
    val_toggle = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // reset in the middle of the value run
    user_cur = 8'h88;
    push_hdr(8'hE1, 8'hE2, 10'd5, 32'h8000, 16'h50);
    send(mk_w0(16'hFFFF, 8'hE1, 8'hE2, 10'd5), 1'b0);
    send(mk_w1(32'h8000, 16'h50), 1'b0);
    push_val(40, 1'b0); send(vw(40), 1'b0);
    push_val(41, 1'b0); send(vw(41), 1'b0);
    rst = 1'b1;
    exp_pkts = 0;
    exp_errs = 0;
    @(negedge clk);
    chk("midrst_in_ready", 32'(in_ready), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("postrst_hdr_valid", 32'(hdr_valid), 0);
    chk("postrst_val_valid", 32'(val_valid), 0);
    chk("postrst_err_valid", 32'(err_valid), 0);
    chk("postrst_in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    user_cur = 8'h99;
    push_hdr(8'hF1, 8'hF2, 10'd2, 32'h9000, 16'h20);
    send(mk_w0(16'hFFFF, 8'hF1, 8'hF2, 10'd2), 1'b0);
    send(mk_w1(32'h9000, 16'h20), 1'b0);
    push_val(50, 1'b0); send(vw(50), 1'b0);
    push_val(51, 1'b1); send(vw(51), 1'b1);
    drain();

    chk("hdr_queue_empty", 32'(hq.size()), 0);
    chk("val_queue_empty", 32'(vq.size()), 0);
    chk("err_queue_empty", 32'(eq.size()), 0);
`ifdef MUU_RESP_PARSE_STATS_EN
    chk("stat_pkts", stat_pkts, 32'(exp_pkts));
    chk("stat_errs", stat_errs, 32'(exp_errs));
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
